// File: rtl/sb_pkg.sv
// Shared types, opcodes and header field positions for the sideband RX capture path.
package sb_pkg;

  localparam int unsigned CAP_DLY_DEF = 2;

  localparam logic [4:0] OP_MSG   = 5'b10010;
  localparam logic [4:0] OP_MSG_D = 5'b11011;

  localparam int OPC_LSB     = 0;
  localparam int OPC_MSB     = 4;
  localparam int MSGCODE_LSB = 14;
  localparam int MSGCODE_MSB = 21;
  localparam int SUBCODE_LSB = 32;
  localparam int SUBCODE_MSB = 39;
  localparam int INFO_LSB    = 40;
  localparam int INFO_MSB    = 55;
  localparam int DP_BIT      = 62;
  localparam int CP_BIT      = 63;

  typedef enum logic [2:0] {
    IDLE,
    HDR_WAIT,
    HDR_CAP,
    DAT_IDLE,
    DAT_WAIT,
    DAT_CAP,
    EMIT
  } sb_rx_cap_st_e;

  function automatic logic is_known_op(input logic [4:0] op);
    return (op == OP_MSG) || (op == OP_MSG_D);
  endfunction

endpackage

// File: rtl/sb_done_edge_det.sv
// Rising-edge detector for the deserializer done level, with a one-deep pending
// flag for edges that arrive while the capture FSM is busy and a sticky overrun flag.
module sb_done_edge_det (
  input  logic i_clk_pll,
  input  logic i_rst_n,
  input  logic i_done,
  input  logic i_accept,
  input  logic i_clr_overrun,
  output logic o_start,
  output logic o_overrun
);

  logic prev_q, prev_d;
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic rise;

  // done stays high until acked, so tracking the level keeps it from retriggering
  always_comb begin
    prev_d    = i_done;
    rise      = i_done & ~prev_q;
    o_start   = i_accept & (rise | pending_q);
    pending_d = pending_q;
    overrun_d = overrun_q & ~i_clr_overrun;
    if (i_accept) begin
      pending_d = pending_q & rise;
    end else if (rise) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_pll or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_overrun = overrun_q;

endmodule

// File: rtl/sb_rx_pkt_capture.sv
// Sideband RX packet capture: acks deserializer words, assembles header(+data) packets
// and presents decoded fields with a one-cycle valid. Optional macro: SB_RX_PARITY_CHK_EN.
module sb_rx_pkt_capture
  import sb_pkg::*;
#(
  parameter int unsigned CAP_DLY = CAP_DLY_DEF
) (
  input  logic        i_clk_pll,
  input  logic        i_rst_n,
  input  logic        i_de_ser_done,
  input  logic [63:0] i_par_data,
  output logic        o_de_ser_done_sampled,
  output logic        o_pkt_valid,
  output logic [63:0] o_hdr,
  output logic [63:0] o_data,
  output logic        o_has_data,
  output logic [4:0]  o_opcode,
  output logic [7:0]  o_msgcode,
  output logic [7:0]  o_msgsubcode,
  output logic [15:0] o_msginfo,
  output logic        o_unknown_op,
  output logic        o_parity_err
);

  localparam int unsigned CNT_W = (CAP_DLY > 1) ? $clog2(CAP_DLY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CAP_DLY - 1);

  sb_rx_cap_st_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      hdr_q, hdr_d;
  logic             ack_q, ack_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic [63:0]      out_hdr_q, out_hdr_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             has_data_q, has_data_d;
  logic             unknown_op_q, unknown_op_d;
  logic             parity_err_q, parity_err_d;

  logic accept;
  logic start;
  logic overrun;
  logic clr_overrun;
  logic par_bad_hdr_only;
  logic par_bad_with_data;

  assign accept = (state_q == IDLE) || (state_q == DAT_IDLE);

  sb_done_edge_det u_done_edge_det (
    .i_clk_pll     (i_clk_pll),
    .i_rst_n       (i_rst_n),
    .i_done        (i_de_ser_done),
    .i_accept      (accept),
    .i_clr_overrun (clr_overrun),
    .o_start       (start),
    .o_overrun     (overrun)
  );

`ifdef SB_RX_PARITY_CHK_EN
  // CP covers header bits 61:0; DP covers the payload and must be 0 without one
  function automatic logic par_mismatch(input logic [63:0] hdr, input logic [63:0] data,
                                        input logic has_data);
    return (hdr[CP_BIT] != ^hdr[61:0]) | (hdr[DP_BIT] != (has_data ? ^data : 1'b0));
  endfunction

  assign par_bad_hdr_only  = par_mismatch(i_par_data, 64'd0, 1'b0);
  assign par_bad_with_data = par_mismatch(hdr_q, i_par_data, 1'b1);
`else
  assign par_bad_hdr_only  = 1'b0;
  assign par_bad_with_data = 1'b0;
`endif

  // Output registers load on the capture cycle so they are valid during EMIT
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hdr_d        = hdr_q;
    ack_d        = 1'b0;
    pkt_valid_d  = 1'b0;
    out_hdr_d    = out_hdr_q;
    out_data_d   = out_data_q;
    has_data_d   = has_data_q;
    unknown_op_d = unknown_op_q;
    parity_err_d = parity_err_q;
    clr_overrun  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      HDR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = HDR_CAP;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HDR_CAP: begin
        hdr_d = i_par_data;
        if (i_par_data[OPC_MSB:OPC_LSB] == OP_MSG_D) begin
          state_d = DAT_IDLE;
        end else begin
          state_d      = EMIT;
          pkt_valid_d  = 1'b1;
          out_hdr_d    = i_par_data;
          out_data_d   = 64'd0;
          has_data_d   = 1'b0;
          unknown_op_d = ~is_known_op(i_par_data[OPC_MSB:OPC_LSB]);
          parity_err_d = overrun | par_bad_hdr_only;
          clr_overrun  = 1'b1;
        end
      end
      DAT_IDLE: begin
        if (start) begin
          state_d = DAT_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      DAT_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DAT_CAP;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DAT_CAP: begin
        state_d      = EMIT;
        pkt_valid_d  = 1'b1;
        out_hdr_d    = hdr_q;
        out_data_d   = i_par_data;
        has_data_d   = 1'b1;
        unknown_op_d = 1'b0;
        parity_err_d = overrun | par_bad_with_data;
        clr_overrun  = 1'b1;
      end
      EMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_pll or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hdr_q        <= 64'd0;
      ack_q        <= 1'b0;
      pkt_valid_q  <= 1'b0;
      out_hdr_q    <= 64'd0;
      out_data_q   <= 64'd0;
      has_data_q   <= 1'b0;
      unknown_op_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hdr_q        <= hdr_d;
      ack_q        <= ack_d;
      pkt_valid_q  <= pkt_valid_d;
      out_hdr_q    <= out_hdr_d;
      out_data_q   <= out_data_d;
      has_data_q   <= has_data_d;
      unknown_op_q <= unknown_op_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign o_de_ser_done_sampled = ack_q;
  assign o_pkt_valid           = pkt_valid_q;
  assign o_hdr                 = out_hdr_q;
  assign o_data                = out_data_q;
  assign o_has_data            = has_data_q;
  assign o_unknown_op          = unknown_op_q;
  assign o_parity_err          = parity_err_q;
  assign o_opcode              = out_hdr_q[OPC_MSB:OPC_LSB];
  assign o_msgcode             = out_hdr_q[MSGCODE_MSB:MSGCODE_LSB];
  assign o_msgsubcode          = out_hdr_q[SUBCODE_MSB:SUBCODE_LSB];
  assign o_msginfo             = out_hdr_q[INFO_MSB:INFO_LSB];

endmodule

// File: tb/tb_sb_rx_pkt_capture.sv
// Scoreboard bench for sb_rx_pkt_capture: directed words in, expected packets queued,
// a negedge monitor pops and compares every o_pkt_valid.
module tb_sb_rx_pkt_capture;

  typedef struct packed {
    logic [63:0] hdr;
    logic [63:0] data;
    logic        has_data;
    logic        unknown;
    logic        par_err;
    logic [4:0]  op;
    logic [7:0]  mc;
    logic [7:0]  sc;
    logic [15:0] mi;
  } exp_t;

  localparam logic [63:0] H1 = 64'h0000_1234_0055_4012;
  localparam logic [63:0] H2 = 64'h0000_5678_00AA_C01B;
  localparam logic [63:0] D2 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] H3 = 64'h0000_0000_0000_0001;
  localparam logic [63:0] H4 = 64'h0011_2233_0004_4012;
  localparam logic [63:0] H5 = 64'h0000_0000_0000_4012;

  logic        clk;
  logic        rst_n;
  logic        done;
  logic [63:0] par_data;
  logic        ack;
  logic        pkt_valid;
  logic [63:0] hdr;
  logic [63:0] data;
  logic        has_data;
  logic [4:0]  opcode;
  logic [7:0]  msgcode;
  logic [7:0]  msgsubcode;
  logic [15:0] msginfo;
  logic        unknown_op;
  logic        parity_err;

  exp_t exp_q[$];
  exp_t mon_exp;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   ack_count = 0;
  int   pkt_count = 0;
  int   cycle_count = 0;
  int   edge_cycle = 0;
  int   last_valid_cycle = 0;
  logic ack_prev = 1'b0;

  sb_rx_pkt_capture dut (
    .i_clk_pll             (clk),
    .i_rst_n               (rst_n),
    .i_de_ser_done         (done),
    .i_par_data            (par_data),
    .o_de_ser_done_sampled (ack),
    .o_pkt_valid           (pkt_valid),
    .o_hdr                 (hdr),
    .o_data                (data),
    .o_has_data            (has_data),
    .o_opcode              (opcode),
    .o_msgcode             (msgcode),
    .o_msgsubcode          (msgsubcode),
    .o_msginfo             (msginfo),
    .o_unknown_op          (unknown_op),
    .o_parity_err          (parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle_count++;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Independent CP/DP reference so the same table serves both builds
  function automatic logic parModel(input logic [63:0] h, input logic [63:0] d, input logic hd);
`ifdef SB_RX_PARITY_CHK_EN
    logic cp_calc;
    logic dp_calc;
    cp_calc = 1'b0;
    for (int i = 0; i < 62; i++) cp_calc = cp_calc ^ h[i];
    dp_calc = 1'b0;
    if (hd) for (int i = 0; i < 64; i++) dp_calc = dp_calc ^ d[i];
    return (h[63] != cp_calc) || (h[62] != dp_calc);
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t mkExp(input logic [63:0] h, input logic [63:0] d, input logic hd,
                                 input logic unk, input logic force_par, input logic [4:0] op,
                                 input logic [7:0] mc, input logic [7:0] sc, input logic [15:0] mi);
    exp_t e;
    e.hdr      = h;
    e.data     = d;
    e.has_data = hd;
    e.unknown  = unk;
    e.par_err  = force_par | parModel(h, d, hd);
    e.op       = op;
    e.mc       = mc;
    e.sc       = sc;
    e.mi       = mi;
    return e;
  endfunction

  // Monitor: counts acks, flags double-width acks, scores every packet
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        ack_count++;
        if (ack_prev) checkOutput("ack_single_cycle", {63'd0, ack_prev}, 64'd0);
      end
      ack_prev = ack;
      if (pkt_valid) begin
        pkt_count++;
        last_valid_cycle = cycle_count;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_pkt: got hdr %h, want no packet", hdr);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("pkt_hdr", hdr, mon_exp.hdr);
          checkOutput("pkt_data", data, mon_exp.data);
          checkOutput("pkt_flags(has,unk,par)", {61'd0, has_data, unknown_op, parity_err},
                      {61'd0, mon_exp.has_data, mon_exp.unknown, mon_exp.par_err});
          checkOutput("pkt_fields(op,mc,sc,mi)", {27'd0, opcode, msgcode, msgsubcode, msginfo},
                      {27'd0, mon_exp.op, mon_exp.mc, mon_exp.sc, mon_exp.mi});
        end
      end
    end else begin
      ack_prev = 1'b0;
    end
  end

  // Raise done with a word, hold it until the ack, then drop it
  task automatic applyStimulus(input logic [63:0] word);
    bit got;
    got = 1'b0;
    @(negedge clk);
    par_data   = word;
    done       = 1'b1;
    edge_cycle = cycle_count;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    done = 1'b0;
    if (!got) checkOutput("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitPackets(input int target);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pkt_count >= target) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("pkt_timeout", 64'(pkt_count), 64'(target));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid_ack"}, {62'd0, pkt_valid, ack}, 64'd0);
    checkOutput({tag, "_hdr"}, hdr, 64'd0);
    checkOutput({tag, "_data"}, data, 64'd0);
    checkOutput({tag, "_flags_fields"},
                {24'd0, has_data, unknown_op, parity_err, opcode, msgcode, msgsubcode, msginfo}, 64'd0);
  endtask

  initial begin
    int a0;
    int p0;
    rst_n    = 1'b0;
    done     = 1'b0;
    par_data = 64'd0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] header-only packet");
    a0 = ack_count; p0 = pkt_count;
    exp_q.push_back(mkExp(H1, 64'd0, 1'b0, 1'b0, 1'b0, 5'h12, 8'h55, 8'h34, 16'h0012));
    applyStimulus(H1);
    waitPackets(p0 + 1);
    checkOutput("t1_latency", 64'(last_valid_cycle - edge_cycle), 64'd4);
    checkOutput("t1_acks", 64'(ack_count - a0), 64'd1);

    $display("[TB] header+data packet");
    a0 = ack_count; p0 = pkt_count;
    exp_q.push_back(mkExp(H2, D2, 1'b1, 1'b0, 1'b0, 5'h1B, 8'hAB, 8'h78, 16'h0056));
    applyStimulus(H2);
    applyStimulus(D2);
    waitPackets(p0 + 1);
    checkOutput("t2_acks", 64'(ack_count - a0), 64'd2);

    $display("[TB] unknown opcode then normal packet");
    p0 = pkt_count;
    exp_q.push_back(mkExp(H3, 64'd0, 1'b0, 1'b1, 1'b0, 5'h01, 8'h00, 8'h00, 16'h0000));
    applyStimulus(H3);
    waitPackets(p0 + 1);
    exp_q.push_back(mkExp(H4, 64'd0, 1'b0, 1'b0, 1'b0, 5'h12, 8'h11, 8'h33, 16'h1122));
    applyStimulus(H4);
    waitPackets(p0 + 2);

    $display("[TB] header with CP flipped");
    p0 = pkt_count;
    exp_q.push_back(mkExp(H5, 64'd0, 1'b0, 1'b0, 1'b0, 5'h12, 8'h01, 8'h00, 16'h0000));
    applyStimulus(H5);
    waitPackets(p0 + 1);

    $display("[TB] back-to-back, second done rises during EMIT");
    a0 = ack_count; p0 = pkt_count;
    exp_q.push_back(mkExp(H1, 64'd0, 1'b0, 1'b0, 1'b0, 5'h12, 8'h55, 8'h34, 16'h0012));
    exp_q.push_back(mkExp(H4, 64'd0, 1'b0, 1'b0, 1'b0, 5'h12, 8'h11, 8'h33, 16'h1122));
    applyStimulus(H1);
    applyStimulus(H4);
    waitPackets(p0 + 2);
    checkOutput("t5_acks", 64'(ack_count - a0), 64'd2);

    $display("[TB] overrun: edges in HDR_WAIT and EMIT");
    p0 = pkt_count;
    exp_q.push_back(mkExp(H1, 64'd0, 1'b0, 1'b0, 1'b0, 5'h12, 8'h55, 8'h34, 16'h0012));
    exp_q.push_back(mkExp(H4, 64'd0, 1'b0, 1'b0, 1'b1, 5'h12, 8'h11, 8'h33, 16'h1122));
    @(negedge clk); par_data = H1; done = 1'b1;
    @(negedge clk); done = 1'b0;
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
    @(negedge clk); done = 1'b1; par_data = H4;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ack) begin
          got = 1'b1;
          break;
        end
      end
      done = 1'b0;
      if (!got) checkOutput("t5b_ack_timeout", 64'd0, 64'd1);
    end
    waitPackets(p0 + 2);

    $display("[TB] reset while waiting for payload");
    p0 = pkt_count;
    applyStimulus(H2);
    @(negedge clk); par_data = D2; done = 1'b1;
    @(negedge clk); rst_n = 1'b0; done = 1'b0;
    @(negedge clk);
    checkAllZero("t6_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t6_no_pkt", 64'(pkt_count - p0), 64'd0);
    exp_q.push_back(mkExp(H1, 64'd0, 1'b0, 1'b0, 1'b0, 5'h12, 8'h55, 8'h34, 16'h0012));
    applyStimulus(H1);
    waitPackets(p0 + 1);

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
